// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - push-button bundle between the board inputs and the conditioner
//
// Purpose: groups the three raw button inputs with the conditioned outputs.
// Signals:
//   buttonRightRaw/buttonCenterRaw/buttonLeftRaw : raw asynchronous buttons, active-high
//   buttonRight/buttonCenter/buttonLeft          : one-cycle press pulses after masking
//   buttonsHeld[2:0]                             : debounced levels {left, center, right}
// Modports: slave = conditioner side, master = button source / observer side.
interface button_conditioner_if;
  logic       buttonRightRaw;
  logic       buttonCenterRaw;
  logic       buttonLeftRaw;
  logic       buttonRight;
  logic       buttonCenter;
  logic       buttonLeft;
  logic [2:0] buttonsHeld;

  modport slave (
    input  buttonRightRaw, buttonCenterRaw, buttonLeftRaw,
    output buttonRight, buttonCenter, buttonLeft, buttonsHeld
  );

  modport master (
    output buttonRightRaw, buttonCenterRaw, buttonLeftRaw,
    input  buttonRight, buttonCenter, buttonLeft, buttonsHeld
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and edge-detect three push-buttons
//
// Purpose: per button a two-flop synchroniser, a restart-on-bounce debounce
// counter and a rising-edge detector; simultaneous rises are masked by a fixed
// priority before being registered as one-cycle press pulses.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   btn   : button_conditioner_if.slave (raw inputs in, pulses and held levels out)
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  button_conditioner_if.slave   btn
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Channel index: 0 = right, 1 = center, 2 = left (matches buttonsHeld order).
  logic [2:0]                raw;
  logic [2:0]                sync1;
  logic [2:0]                sync2;
  logic [2:0]                level;
  logic [2:0]                level_next;
  logic [2:0][CNT_WIDTH-1:0] cnt;
  logic [2:0][CNT_WIDTH-1:0] cnt_next;
  logic [2:0]                rise;
  logic [2:0]                accept;
  logic [2:0]                pulse;

  assign raw = {btn.buttonLeftRaw, btn.buttonCenterRaw, btn.buttonRightRaw};

  // Debounce: the count only advances while the synchronised input disagrees
  // with the stable level, so any bounce back clears it and it never wraps.
  always_comb begin
    level_next = level;
    cnt_next   = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_MAX) begin
          level_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Rise is taken from the level change happening at this edge so the pulse
  // appears together with the new buttonsHeld value.
  assign rise = level_next & ~level;

  // Center wins outright; left+right together is ambiguous and dropped.
  always_comb begin
    accept = rise;
    if (rise[1]) begin
      accept = 3'b010;
    end else if (rise[2] && rise[0]) begin
      accept = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      cnt   <= '0;
      pulse <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_next;
      cnt   <= cnt_next;
      pulse <= accept;
    end
  end

  assign btn.buttonRight  = pulse[0];
  assign btn.buttonCenter = pulse[1];
  assign btn.buttonLeft   = pulse[2];
  assign btn.buttonsHeld  = level;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage for the multiplier control unit's three push-buttons: right, center and left.
- For each button it synchronises the raw asynchronous input, debounces it with a counter, and emits a single-cycle press pulse.
- Press pulses drive the controlUnit inputs buttonRight, buttonCenter and buttonLeft directly.
- Simultaneous presses are resolved by a fixed priority so the control unit never sees conflicting pulses in one cycle.

Parameters:
- DEBOUNCE_CYCLES, default 500000 (5 ms at 100 MHz): number of consecutive cycles a synchronised input must differ from its stable level before the level flips. Legal range 2 or more.
- CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES): width of each debounce counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- buttonRightRaw  input  1  raw right push-button, asynchronous, active-high
- buttonCenterRaw  input  1  raw center push-button, asynchronous, active-high
- buttonLeftRaw  input  1  raw left push-button, asynchronous, active-high
- buttonRight  output  1  one-cycle press pulse for right, after masking
- buttonCenter  output  1  one-cycle press pulse for center, after masking
- buttonLeft  output  1  one-cycle press pulse for left, after masking
- buttonsHeld  output  3  debounced stable levels {left, center, right}, unmasked

Behaviour:
- Reset:
  - Synchronous: sampled on posedge clk while reset=1.
  - Clears both synchroniser flops, stable levels, counters and pulse registers of all channels.
  - All outputs are 0 from the first edge after reset is sampled.
- Synchroniser: two-flop chain per channel, sync1 <= raw, sync2 <= sync1. No logic between the flops.
- Debounce, per channel:
  - If sync2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the stable level before the count completes restarts the count from 0.
- Edge detect: rise_x is 1 exactly at the edge where level_x changes 0->1. A 1->0 change produces no pulse.
- Priority masking, applied to the rise vector at the same edge:
  - Center rise present: only buttonCenter pulses; left and right rises are discarded.
  - Left and right rise together without center: both are discarded, no pulse.
  - Otherwise: each rise passes through.
  - Discarded rises are never replayed later.
- Outputs:
  - Press pulses are registered and high for exactly one cycle per accepted press.
  - buttonsHeld equals the level registers.
- Latency: a raw input that changes before posedge k and stays clean produces its level change and pulse visible after posedge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles. Release is detected with the same latency.
- Held button: one pulse only, no auto-repeat. A new pulse requires a debounced release followed by a debounced press.
- Reset mid-count: the count is lost. A button still held when reset deasserts is treated as a fresh press and pulses DEBOUNCE_CYCLES+2 cycles after the reset deassertion edge.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Channels are fully independent except for the masking step.

Test Plan:
- DEBOUNCE_CYCLES=4; reset, then hold buttonCenterRaw=1 from before edge 10 -> buttonsHeld[1] rises and buttonCenter=1 for exactly one cycle after edge 15; buttonCenter stays 0 afterwards while held; no other output toggles.
- DEBOUNCE_CYCLES=4; buttonLeftRaw pattern high 3 cycles, low 1 cycle, high 3 cycles, low -> no buttonLeft pulse and buttonsHeld stays 3'b000. A later clean 6-cycle high gives exactly one pulse at latency 6.
- DEBOUNCE_CYCLES=4; buttonLeftRaw and buttonCenterRaw rise on the same cycle -> buttonCenter pulses once, buttonLeft stays 0, buttonsHeld=3'b110.
- DEBOUNCE_CYCLES=4; buttonLeftRaw and buttonRightRaw rise on the same cycle -> no pulses, buttonsHeld=3'b101. Release both, then press right alone -> buttonRight pulses once.
- DEBOUNCE_CYCLES=4; press right, assert reset for 1 cycle at count 2, keep right held -> no pulse before reset; buttonsHeld=0 after reset; buttonRight pulses 6 cycles after reset deasserts.
- DEBOUNCE_CYCLES=4; press right, release and repress 10 times with clean 8-cycle phases -> exactly 10 buttonRight pulses, each 6 cycles after its rising raw edge, and none on releases.
